// File: rtl/dcache_pkg.sv
// Shared state type, field widths and line word helpers for the data-cache controller.
package dcache_pkg;

   localparam int ADDR_W      = 32;
   localparam int WORD_W      = 32;
   localparam int TAG_W       = 23;
   localparam int IDX_W       = 4;
   localparam int OFFSET_W    = 5;
   localparam int LINE_W      = 256;
   localparam int WORD_SEL_W  = 3;
   localparam int TAG_FIELD_W = TAG_W + 2;
   localparam int VALID_BIT   = 24;
   localparam int DIRTY_BIT   = 23;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MISS,
      ST_WRITEBACK,
      ST_REFILL,
      ST_REFILL_DONE
   } state_e;

   function automatic logic [WORD_W-1:0] line_word(
      input logic [LINE_W-1:0]     line,
      input logic [WORD_SEL_W-1:0] sel
   );
      return line[{sel, 5'b00000} +: WORD_W];
   endfunction

   function automatic logic [LINE_W-1:0] line_merge(
      input logic [LINE_W-1:0]     line,
      input logic [WORD_SEL_W-1:0] sel,
      input logic [WORD_W-1:0]     word
   );
      logic [LINE_W-1:0] merged;
      merged = line;
      merged[{sel, 5'b00000} +: WORD_W] = word;
      return merged;
   endfunction

endpackage

// File: rtl/dcache_ctrl.sv
// Write-back data-cache controller: hit service in IDLE, victim write-back and
// line refill through a single-outstanding memory port.
//
// state          | meaning
// ST_IDLE        | serve hits combinationally, detect misses
// ST_MISS        | inspect victim, capture it if it must be written back
// ST_WRITEBACK   | dirty victim line going out to memory
// ST_REFILL      | fetching requested line, installed in SRAM on ack
// ST_REFILL_DONE | settle cycle so the SRAM read reflects the new line
module dcache_ctrl
   import dcache_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   rst_i,

   input  logic                   cpu_req_i,
   input  logic                   cpu_we_i,
   input  logic [ADDR_W-1:0]      cpu_addr_i,
   input  logic [WORD_W-1:0]      cpu_data_i,
   output logic [WORD_W-1:0]      cpu_data_o,
   output logic                   cpu_stall_o,

   output logic                   sram_enable_o,
   output logic                   sram_write_o,
   output logic [IDX_W-1:0]       sram_addr_o,
   output logic [TAG_FIELD_W-1:0] sram_tag_o,
   output logic [LINE_W-1:0]      sram_data_o,
   input  logic [TAG_FIELD_W-1:0] sram_tag_i,
   input  logic [LINE_W-1:0]      sram_data_i,
   input  logic                   sram_hit_i,

   output logic                   mem_enable_o,
   output logic                   mem_write_o,
   output logic [ADDR_W-1:0]      mem_addr_o,
   output logic [LINE_W-1:0]      mem_data_o,
   input  logic [LINE_W-1:0]      mem_data_i,
   input  logic                   mem_ack_i
);

   state_e             state_q, state_d;
   logic [LINE_W-1:0]  wb_line_q, wb_line_d;
   logic [TAG_W-1:0]   wb_tag_q, wb_tag_d;

   logic [TAG_W-1:0]      req_tag;
   logic [IDX_W-1:0]      req_idx;
   logic [WORD_SEL_W-1:0] req_word;
   logic                  victim_dirty;

   assign req_tag      = cpu_addr_i[31:9];
   assign req_idx      = cpu_addr_i[8:5];
   assign req_word     = cpu_addr_i[4:2];
   assign victim_dirty = sram_tag_i[VALID_BIT] & sram_tag_i[DIRTY_BIT];

   assign sram_addr_o = req_idx;
   assign mem_data_o  = wb_line_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         wb_line_q <= '0;
         wb_tag_q  <= '0;
      end else begin
         state_q   <= state_d;
         wb_line_q <= wb_line_d;
         wb_tag_q  <= wb_tag_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      wb_line_d     = wb_line_q;
      wb_tag_d      = wb_tag_q;
      cpu_data_o    = '0;
      cpu_stall_o   = 1'b1;
      sram_enable_o = 1'b0;
      sram_write_o  = 1'b0;
      sram_tag_o    = {2'b00, req_tag};
      sram_data_o   = '0;
      mem_enable_o  = 1'b0;
      mem_write_o   = 1'b0;
      mem_addr_o    = '0;

      case (state_q)
         ST_IDLE: begin
            cpu_stall_o = 1'b0;
            if (cpu_req_i) begin
               if (sram_hit_i) begin
                  if (cpu_we_i) begin
                     sram_enable_o = 1'b1;
                     sram_write_o  = 1'b1;
                     sram_tag_o    = {2'b11, req_tag};
                     sram_data_o   = line_merge(sram_data_i, req_word, cpu_data_i);
                  end else begin
                     cpu_data_o = line_word(sram_data_i, req_word);
                  end
               end else begin
                  cpu_stall_o = 1'b1;
                  state_d     = ST_MISS;
               end
            end
         end

         ST_MISS: begin
            // Victim is snapshotted here so write-back data and address stay
            // fixed however long memory takes to accept them.
            if (victim_dirty) begin
               wb_line_d = sram_data_i;
               wb_tag_d  = sram_tag_i[TAG_W-1:0];
               state_d   = ST_WRITEBACK;
            end else begin
               state_d = ST_REFILL;
            end
         end

         ST_WRITEBACK: begin
            mem_enable_o = 1'b1;
            mem_write_o  = 1'b1;
            mem_addr_o   = {wb_tag_q, req_idx, {OFFSET_W{1'b0}}};
            if (mem_ack_i) begin
               state_d = ST_REFILL;
            end
         end

         ST_REFILL: begin
            mem_enable_o = 1'b1;
            mem_addr_o   = {cpu_addr_i[31:5], {OFFSET_W{1'b0}}};
            if (mem_ack_i) begin
               sram_enable_o = 1'b1;
               sram_write_o  = 1'b1;
               sram_tag_o    = {2'b10, req_tag};
               sram_data_o   = mem_data_i;
               state_d       = ST_REFILL_DONE;
            end
         end

         ST_REFILL_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: direct-mapped SRAM and latency-programmable memory
// models around the DUT, checked against a flat-memory reference.
module tb_dcache_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         cpu_req, cpu_we;
   logic [31:0]  cpu_addr, cpu_wdata;
   logic [31:0]  cpu_data_o;
   logic         cpu_stall_o;
   logic         sram_enable_o, sram_write_o;
   logic [3:0]   sram_addr_o;
   logic [24:0]  sram_tag_o;
   logic [255:0] sram_data_o;
   logic [24:0]  sram_tag_i;
   logic [255:0] sram_data_i;
   logic         sram_hit_i;
   logic         mem_enable_o, mem_write_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o;
   logic [255:0] mem_data_i;
   logic         mem_ack_i;

   int checks = 0;
   int failures = 0;

   int           mem_lat = 4;
   logic         spur_ack = 1'b0;
   logic         ack_q = 1'b0;
   int           lat_cnt = 0;
   logic [255:0] rdata_q = '0;
   int           n_wb = 0, n_rd = 0, n_sram_wr = 0;
   logic [31:0]  last_wb_addr = '0, last_rd_addr = '0;
   logic [255:0] last_wb_data = '0;
   logic [24:0]  last_sram_wtag = '0;
   logic [255:0] last_sram_wdata = '0;

   logic [24:0]  s_tag  [16];
   logic [255:0] s_data [16];
   logic [31:0]  mem_words [1024];
   logic         pl_en = 1'b0, pl_clr = 1'b0, mem_clr = 1'b0;
   logic [3:0]   pl_idx = '0;
   logic [24:0]  pl_tag = '0;
   logic [255:0] pl_line = '0;

   logic [31:0]  ref_words [1024];
   bit           rv [16];
   bit           rdty [16];
   logic [22:0]  rt [16];

   dcache_ctrl dut (
      .clk_i(clk), .rst_i(rst),
      .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_wdata),
      .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
      .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o), .sram_addr_o(sram_addr_o),
      .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
      .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
      .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_init(input int i);
      return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   assign sram_tag_i  = s_tag[sram_addr_o];
   assign sram_data_i = s_data[sram_addr_o];
   assign sram_hit_i  = s_tag[sram_addr_o][24] && (s_tag[sram_addr_o][22:0] == cpu_addr[31:9]);
   assign mem_data_i  = rdata_q;
   assign mem_ack_i   = ack_q | spur_ack;

   always @(posedge clk) begin
      if (pl_clr) begin
         for (int i = 0; i < 16; i++) begin
            s_tag[i]  <= '0;
            s_data[i] <= '0;
         end
      end else if (pl_en) begin
         s_tag[pl_idx]  <= pl_tag;
         s_data[pl_idx] <= pl_line;
      end else if (sram_enable_o && sram_write_o) begin
         s_tag[sram_addr_o]  <= sram_tag_o;
         s_data[sram_addr_o] <= sram_data_o;
         n_sram_wr       <= n_sram_wr + 1;
         last_sram_wtag  <= sram_tag_o;
         last_sram_wdata <= sram_data_o;
      end
   end

   // Memory answers with ack in the mem_lat-th cycle of an enabled request.
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 1024; i++) mem_words[i] <= word_init(i);
      end
      if (rst) begin
         ack_q   <= 1'b0;
         lat_cnt <= 0;
      end else if (ack_q) begin
         ack_q   <= 1'b0;
         lat_cnt <= 0;
         if (mem_write_o) begin
            for (int i = 0; i < 8; i++)
               mem_words[{mem_addr_o[11:5], 3'(i)}] <= mem_data_o[i*32 +: 32];
            n_wb         <= n_wb + 1;
            last_wb_addr <= mem_addr_o;
            last_wb_data <= mem_data_o;
         end else begin
            n_rd         <= n_rd + 1;
            last_rd_addr <= mem_addr_o;
         end
      end else if (mem_enable_o) begin
         lat_cnt <= lat_cnt + 1;
         if (lat_cnt + 1 == mem_lat - 1) begin
            ack_q <= 1'b1;
            for (int i = 0; i < 8; i++)
               rdata_q[i*32 +: 32] <= mem_words[{mem_addr_o[11:5], 3'(i)}];
         end
      end
   end

   task automatic preload(input logic [3:0] idx, input logic [24:0] tag, input logic [255:0] line);
      @(posedge clk); #1;
      pl_en = 1'b1; pl_idx = idx; pl_tag = tag; pl_line = line;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            output int stalls, output logic [31:0] rdata, output bit timeout);
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      stalls = 0; rdata = '0; timeout = 1'b1;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (!cpu_stall_o) begin
            rdata = cpu_data_o;
            timeout = 1'b0;
            break;
         end
         stalls++;
      end
      @(posedge clk); #1;
      cpu_req = 1'b0; cpu_we = 1'b0;
   endtask

   function automatic logic [255:0] init_line(input logic [31:0] addr);
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = word_init(int'({addr[11:5], 3'(i)}));
      return l;
   endfunction

   task automatic test_reset();
      rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      pl_clr = 1'b1; mem_clr = 1'b1;
      repeat (2) @(posedge clk);
      #1; pl_clr = 1'b0; mem_clr = 1'b0;
      @(negedge clk);
      checks++;
      if ({cpu_stall_o, sram_enable_o, sram_write_o, mem_enable_o, mem_write_o} !== 5'b0) begin
         failures++;
         $display("FAIL reset_strobes: got %b expected 00000",
                  {cpu_stall_o, sram_enable_o, sram_write_o, mem_enable_o, mem_write_o});
      end
      checks++;
      if (cpu_data_o !== 32'h0) begin
         failures++; $display("FAIL reset_cpu_data: got %h expected 0", cpu_data_o);
      end
      checks++;
      if (mem_data_o !== 256'h0) begin
         failures++; $display("FAIL reset_wb_line: got %h expected 0", mem_data_o);
      end
      @(posedge clk); #1; rst = 1'b0;
   endtask

   task automatic test_load_hit();
      logic [255:0] line; int st; logic [31:0] rd; bit to; int wr0;
      for (int i = 0; i < 8; i++) line[i*32 +: 32] = $urandom;
      line[3*32 +: 32] = 32'hDEAD_BEEF;
      preload(4'd1, 25'h1_000000, line);
      wr0 = n_sram_wr;
      do_access(1'b0, 32'h0000_002C, 32'h0, st, rd, to);
      checks++;
      if (to || st != 0) begin
         failures++; $display("FAIL load_hit_stall: got %0d (timeout %0d) expected 0", st, to);
      end
      checks++;
      if (rd !== 32'hDEAD_BEEF) begin
         failures++; $display("FAIL load_hit_data: got %h expected deadbeef", rd);
      end
      checks++;
      if (n_sram_wr != wr0) begin
         failures++; $display("FAIL load_hit_no_write: got %0d writes expected 0", n_sram_wr - wr0);
      end
   endtask

   task automatic test_store_hit();
      logic [255:0] line, exp_line; int st; logic [31:0] rd; bit to; int wr0;
      for (int i = 0; i < 8; i++) line[i*32 +: 32] = $urandom;
      preload(4'd1, 25'h1_000000, line);
      exp_line = line;
      exp_line[31:0] = 32'h1234_5678;
      wr0 = n_sram_wr;
      do_access(1'b1, 32'h0000_0020, 32'h1234_5678, st, rd, to);
      checks++;
      if (to || st != 0) begin
         failures++; $display("FAIL store_hit_stall: got %0d (timeout %0d) expected 0", st, to);
      end
      checks++;
      if (n_sram_wr - wr0 != 1) begin
         failures++; $display("FAIL store_hit_writes: got %0d expected 1", n_sram_wr - wr0);
      end
      checks++;
      if (last_sram_wtag !== 25'h180_0000) begin
         failures++; $display("FAIL store_hit_tag: got %h expected 1800000", last_sram_wtag);
      end
      checks++;
      if (last_sram_wdata !== exp_line) begin
         failures++; $display("FAIL store_hit_line: got %h expected %h", last_sram_wdata, exp_line);
      end
   endtask

   task automatic test_clean_miss();
      int st; logic [31:0] rd; bit to; int wb0, rd0, wr0;
      preload(4'd2, {2'b10, 23'h7}, {8{32'hCAFE_F00D}});
      wb0 = n_wb; rd0 = n_rd; wr0 = n_sram_wr;
      mem_lat = 10;
      do_access(1'b0, 32'h0000_0040, 32'h0, st, rd, to);
      checks++;
      if (to || st != 13) begin
         failures++; $display("FAIL clean_miss_stall: got %0d (timeout %0d) expected 13", st, to);
      end
      checks++;
      if (n_wb != wb0 || n_rd - rd0 != 1) begin
         failures++; $display("FAIL clean_miss_txns: got wb=%0d rd=%0d expected wb=0 rd=1", n_wb - wb0, n_rd - rd0);
      end
      checks++;
      if (last_rd_addr !== 32'h0000_0040) begin
         failures++; $display("FAIL clean_miss_addr: got %h expected 00000040", last_rd_addr);
      end
      checks++;
      if (rd !== word_init(16)) begin
         failures++; $display("FAIL clean_miss_data: got %h expected %h", rd, word_init(16));
      end
      checks++;
      if (n_sram_wr - wr0 != 1 || s_tag[2] !== 25'h100_0000) begin
         failures++; $display("FAIL clean_miss_install: got writes=%0d tag=%h expected 1 1000000", n_sram_wr - wr0, s_tag[2]);
      end
   endtask

   task automatic test_dirty_miss();
      logic [255:0] victim, exp_line; int st; logic [31:0] rd; bit to;
      for (int i = 0; i < 8; i++) victim[i*32 +: 32] = $urandom;
      preload(4'd2, {2'b11, 23'h5}, victim);
      exp_line = init_line(32'h40);
      exp_line[1*32 +: 32] = 32'hA5C3_0F11;
      mem_lat = 3;
      do_access(1'b1, 32'h0000_0044, 32'hA5C3_0F11, st, rd, to);
      checks++;
      if (to || st != 9) begin
         failures++; $display("FAIL dirty_miss_stall: got %0d (timeout %0d) expected 9", st, to);
      end
      checks++;
      if (last_wb_addr !== 32'h0000_0A40) begin
         failures++; $display("FAIL dirty_miss_wb_addr: got %h expected 00000a40", last_wb_addr);
      end
      checks++;
      if (last_wb_data !== victim) begin
         failures++; $display("FAIL dirty_miss_wb_data: got %h expected %h", last_wb_data, victim);
      end
      checks++;
      if (last_rd_addr !== 32'h0000_0040) begin
         failures++; $display("FAIL dirty_miss_rd_addr: got %h expected 00000040", last_rd_addr);
      end
      checks++;
      if (s_tag[2] !== 25'h180_0000 || s_data[2] !== exp_line) begin
         failures++; $display("FAIL dirty_miss_final: got tag=%h line=%h expected 1800000 %h", s_tag[2], s_data[2], exp_line);
      end
   endtask

   task automatic test_spurious_ack();
      int st; logic [31:0] rd; bit to; int wr0;
      wr0 = n_sram_wr;
      @(posedge clk); #1; spur_ack = 1'b1;
      @(negedge clk);
      checks++;
      if ({cpu_stall_o, sram_enable_o, sram_write_o, mem_enable_o} !== 4'b0) begin
         failures++; $display("FAIL spur_ack_strobes: got %b expected 0000", {cpu_stall_o, sram_enable_o, sram_write_o, mem_enable_o});
      end
      @(posedge clk); #1; spur_ack = 1'b0;
      @(negedge clk);
      checks++;
      if ({cpu_stall_o, mem_enable_o} !== 2'b0 || n_sram_wr != wr0) begin
         failures++; $display("FAIL spur_ack_after: got stall/mem=%b writes=%0d expected 00 0", {cpu_stall_o, mem_enable_o}, n_sram_wr - wr0);
      end
      do_access(1'b0, 32'h0000_0044, 32'h0, st, rd, to);
      checks++;
      if (to || st != 0 || rd !== 32'hA5C3_0F11) begin
         failures++; $display("FAIL spur_ack_followup: got stall=%0d data=%h expected 0 a5c30f11", st, rd);
      end
   endtask

   task automatic test_reset_refill();
      int seen; int rd0, wr0, st; logic [31:0] rd; bit to;
      rd0 = n_rd; wr0 = n_sram_wr;
      mem_lat = 60;
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0060;
      seen = 0;
      for (int c = 0; c < 40 && seen < 3; c++) begin
         @(negedge clk);
         if (mem_enable_o && !mem_write_o) seen++;
      end
      checks++;
      if (seen < 3) begin
         failures++; $display("FAIL reset_refill_wait: got %0d refill cycles expected 3", seen);
      end
      @(posedge clk); #1; rst = 1'b1; cpu_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({mem_enable_o, sram_enable_o, sram_write_o, cpu_stall_o} !== 4'b0) begin
         failures++; $display("FAIL reset_refill_strobes: got %b expected 0000", {mem_enable_o, sram_enable_o, sram_write_o, cpu_stall_o});
      end
      checks++;
      if (n_sram_wr != wr0 || n_rd != rd0) begin
         failures++; $display("FAIL reset_refill_side_effects: got writes=%0d reads=%0d expected 0 0", n_sram_wr - wr0, n_rd - rd0);
      end
      @(posedge clk); #1; rst = 1'b0;
      mem_lat = 4;
      do_access(1'b0, 32'h0000_0060, 32'h0, st, rd, to);
      checks++;
      if (to || st != 7 || rd !== word_init(24)) begin
         failures++; $display("FAIL reset_refill_retry: got stall=%0d data=%h expected 7 %h", st, rd, word_init(24));
      end
   endtask

   task automatic test_random();
      int st, exp_st, lat, exp_wb, exp_rd, wb0, rd0, idx, wsel;
      logic [22:0] tg; logic [31:0] addr, wdata, rd, exp_rd_data; logic we; bit to, hit, dirty_victim;
      logic [24:0] exp_tag;
      @(posedge clk); #1; pl_clr = 1'b1; mem_clr = 1'b1;
      @(posedge clk); #1; pl_clr = 1'b0; mem_clr = 1'b0;
      for (int i = 0; i < 1024; i++) ref_words[i] = word_init(i);
      for (int i = 0; i < 16; i++) begin rv[i] = 0; rdty[i] = 0; rt[i] = '0; end
      exp_wb = 0; exp_rd = 0; wb0 = n_wb; rd0 = n_rd;
      for (int n = 0; n < 200; n++) begin
         tg    = 23'($urandom_range(0, 3));
         idx   = $urandom_range(0, 3);
         wsel  = $urandom_range(0, 7);
         addr  = {tg, 4'(idx), 3'(wsel), 2'b00};
         we    = 1'($urandom_range(0, 1));
         wdata = $urandom;
         lat   = $urandom_range(2, 5);
         mem_lat = lat;
         hit = rv[idx] && rt[idx] == tg;
         dirty_victim = !hit && rv[idx] && rdty[idx];
         exp_st = hit ? 0 : (dirty_victim ? 3 + 2 * lat : 3 + lat);
         if (!hit) begin
            exp_rd++;
            if (dirty_victim) exp_wb++;
            rv[idx] = 1; rdty[idx] = 0; rt[idx] = tg;
         end
         exp_rd_data = ref_words[addr[11:2]];
         if (we) begin
            ref_words[addr[11:2]] = wdata;
            rdty[idx] = 1;
         end
         do_access(we, addr, wdata, st, rd, to);
         checks++;
         if (to || st != exp_st) begin
            failures++; $display("FAIL rand_stall[%0d]: addr %h got %0d (timeout %0d) expected %0d", n, addr, st, to, exp_st);
         end
         if (!we) begin
            checks++;
            if (rd !== exp_rd_data) begin
               failures++; $display("FAIL rand_load[%0d]: addr %h got %h expected %h", n, addr, rd, exp_rd_data);
            end
         end
      end
      checks++;
      if (n_wb - wb0 != exp_wb || n_rd - rd0 != exp_rd) begin
         failures++; $display("FAIL rand_mem_txns: got wb=%0d rd=%0d expected wb=%0d rd=%0d", n_wb - wb0, n_rd - rd0, exp_wb, exp_rd);
      end
      for (int i = 0; i < 4; i++) begin
         exp_tag = {1'(rv[i]), 1'(rv[i] && rdty[i]), rt[i]};
         checks++;
         if (s_tag[i] !== exp_tag) begin
            failures++; $display("FAIL rand_dir[%0d]: got %h expected %h", i, s_tag[i], exp_tag);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_hit();
      test_store_hit();
      test_clean_miss();
      test_dirty_miss();
      test_spurious_ack();
      test_reset_refill();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
